// File: rtl/mem_bist_march_ctrl.sv
// March C- BIST controller for a single-port memory macro.
// Drives one memory operation per cycle and checks read data through an RD_LAT-deep compare pipeline.
module mem_bist_march_ctrl #(
   parameter int                ADDR_W = 4,
   parameter int                DEPTH  = 16,
   parameter int                DATA_W = 64,
   parameter int                RD_LAT = 1,
   parameter logic [DATA_W-1:0] BG_PAT = DATA_W'({DATA_W{2'b01}}),
   parameter int                FCNT_W = 8
) (
   input  logic              bist_clk,
   input  logic              bist_reset_n,
   input  logic              bist_on,
   output logic              bist_en,
   output logic              bist_we,
   output logic [ADDR_W-1:0] bist_addr,
   output logic [DATA_W-1:0] bist_wr_data,
   input  logic [DATA_W-1:0] bist_rd_data,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_fail,
   output logic [ADDR_W-1:0] bist_fail_addr,
   output logic [FCNT_W-1:0] bist_fail_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [1:0]        FLUSH_LAST = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          elem_q, elem_d;
   logic                op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          flush_cnt_q, flush_cnt_d;
   logic                en_q, en_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [DATA_W-1:0]   rd_exp_q, rd_exp_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                fail_q;
   logic [ADDR_W-1:0]   fail_addr_q;
   logic [FCNT_W-1:0]   fail_cnt_q;

   logic                last_op, desc, at_end, issue, start, abort, mismatch;

   logic                pipe_vld_q  [RD_LAT];
   logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];
   logic [DATA_W-1:0]   pipe_exp_q  [RD_LAT];

   // Elements 3 and 4 walk downwards; elements 0 and 5 have a single operation.
   assign desc    = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign last_op = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
   assign at_end  = desc ? (addr_q == '0) : (addr_q == LAST_ADDR);
   assign start   = (state_q == S_IDLE) && bist_on;
   assign abort   = ((state_q == S_RUN) || (state_q == S_FLUSH)) && !bist_on;

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      op_d        = op_q;
      addr_d      = addr_q;
      flush_cnt_d = flush_cnt_q;
      issue       = 1'b0;
      en_d        = 1'b0;
      we_d        = 1'b0;
      wr_data_d   = '0;
      rd_exp_d    = '0;
      case (state_q)
         S_IDLE: begin
            if (bist_on) begin
               state_d = S_RUN;
               elem_d  = 3'd0;
               op_d    = 1'b0;
               addr_d  = '0;
               issue   = 1'b1;
            end
         end
         S_RUN: begin
            if (!bist_on) begin
               state_d = S_IDLE;
               elem_d  = 3'd0;
               op_d    = 1'b0;
               addr_d  = '0;
            end else if (!last_op) begin
               op_d  = 1'b1;
               issue = 1'b1;
            end else if (!at_end) begin
               op_d   = 1'b0;
               addr_d = desc ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
               issue  = 1'b1;
            end else if (elem_q == 3'd5) begin
               state_d     = S_FLUSH;
               addr_d      = '0;
               flush_cnt_d = 2'd0;
            end else begin
               elem_d = elem_q + 3'd1;
               op_d   = 1'b0;
               addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_ADDR : '0;
               issue  = 1'b1;
            end
         end
         S_FLUSH: begin
            if (!bist_on) begin
               state_d = S_IDLE;
            end else if (flush_cnt_q == FLUSH_LAST) begin
               state_d = S_DONE;
            end else begin
               flush_cnt_d = flush_cnt_q + 2'd1;
            end
         end
         S_DONE: begin
            if (!bist_on) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Op 0 of elements 1..5 is a read; everything else writes the complement of what was read.
      if (issue) begin
         en_d = 1'b1;
         if ((elem_d != 3'd0) && !op_d) begin
            rd_exp_d = ((elem_d == 3'd2) || (elem_d == 3'd4)) ? ~BG_PAT : BG_PAT;
         end else begin
            we_d      = 1'b1;
            wr_data_d = ((elem_d == 3'd1) || (elem_d == 3'd3)) ? ~BG_PAT : BG_PAT;
         end
      end
   end

   assign busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
   assign done_d = (state_d == S_DONE);

   always_ff @(posedge bist_clk or negedge bist_reset_n) begin
      if (!bist_reset_n) begin
         state_q     <= S_IDLE;
         elem_q      <= 3'd0;
         op_q        <= 1'b0;
         addr_q      <= '0;
         flush_cnt_q <= 2'd0;
         en_q        <= 1'b0;
         we_q        <= 1'b0;
         wr_data_q   <= '0;
         rd_exp_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         flush_cnt_q <= flush_cnt_d;
         en_q        <= en_d;
         we_q        <= we_d;
         wr_data_q   <= wr_data_d;
         rd_exp_q    <= rd_exp_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   genvar gi;
   for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
         always_ff @(posedge bist_clk or negedge bist_reset_n) begin
            if (!bist_reset_n) begin
               pipe_vld_q[0]  <= 1'b0;
               pipe_addr_q[0] <= '0;
               pipe_exp_q[0]  <= '0;
            end else begin
               pipe_vld_q[0]  <= en_q && !we_q && !abort;
               pipe_addr_q[0] <= addr_q;
               pipe_exp_q[0]  <= rd_exp_q;
            end
         end
      end else begin : g_tail
         always_ff @(posedge bist_clk or negedge bist_reset_n) begin
            if (!bist_reset_n) begin
               pipe_vld_q[gi]  <= 1'b0;
               pipe_addr_q[gi] <= '0;
               pipe_exp_q[gi]  <= '0;
            end else begin
               pipe_vld_q[gi]  <= pipe_vld_q[gi-1] && !abort;
               pipe_addr_q[gi] <= pipe_addr_q[gi-1];
               pipe_exp_q[gi]  <= pipe_exp_q[gi-1];
            end
         end
      end
   end

   assign mismatch = pipe_vld_q[RD_LAT-1] && (bist_rd_data != pipe_exp_q[RD_LAT-1]);

   always_ff @(posedge bist_clk or negedge bist_reset_n) begin
      if (!bist_reset_n) begin
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_cnt_q  <= '0;
      end else if (start) begin
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_cnt_q  <= '0;
      end else if (mismatch) begin
         fail_q <= 1'b1;
         if (!fail_q) begin
            fail_addr_q <= pipe_addr_q[RD_LAT-1];
         end
         if (fail_cnt_q != '1) begin
            fail_cnt_q <= fail_cnt_q + FCNT_W'(1);
         end
      end
   end

   assign bist_en        = en_q;
   assign bist_we        = we_q;
   assign bist_addr      = addr_q;
   assign bist_wr_data   = wr_data_q;
   assign bist_busy      = busy_q;
   assign bist_done      = done_q;
   assign bist_fail      = fail_q;
   assign bist_fail_addr = fail_addr_q;
   assign bist_fail_cnt  = fail_cnt_q;

endmodule
